// File: rtl/prog_loader.sv
// +----------------------------------------------------------------------------+
// | prog_loader: buffers instruction/operand pairs and streams them, preceded  |
// | by a start address, into the processor's data_in; then raises start.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module prog_loader #(
  parameter int AW    = 4,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_instr,
  input  logic [7:0]    wr_oper,
  input  logic [7:0]    base_addr,
  input  logic [AW:0]   count,
  input  logic          go,
  output logic [7:0]    data_out,
  output logic          data_valid,
  output logic          start,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    INSTR = 3'd2,
    OPER  = 3'd3,
    RUN   = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t        state, state_n;
  logic [7:0]    instr_mem [DEPTH];
  logic [7:0]    oper_mem  [DEPTH];
  logic [7:0]    base, base_n;
  logic [AW:0]   cnt, cnt_n;
  logic [AW-1:0] idx, idx_n;
  logic [7:0]    data_n;
  logic          valid_n, start_n, busy_n, done_n;
  logic          quiet;
  logic          accept;
  logic          wr_ok;

  // busy also covers the first RUN cycle, while the last byte is still on the bus
  assign quiet  = (state == IDLE || state == RUN) && !busy;
  assign accept = go && quiet;
  assign wr_ok  = wr_en && quiet;

  // The buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      instr_mem[wr_addr] <= wr_instr;
      oper_mem[wr_addr]  <= wr_oper;
    end
  end

  always_comb begin
    state_n = state;
    base_n  = base;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = 8'd0;
    valid_n = 1'b0;
    start_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          base_n  = base_addr;
          cnt_n   = (count > DEPTH_C) ? DEPTH_C : count;
          idx_n   = '0;
          state_n = ADDR;
        end
      end
      ADDR: begin
        data_n  = base;
        valid_n = 1'b1;
        state_n = (cnt == '0) ? RUN : INSTR;
      end
      INSTR: begin
        data_n  = instr_mem[idx];
        valid_n = 1'b1;
        state_n = OPER;
      end
      OPER: begin
        data_n  = oper_mem[idx];
        valid_n = 1'b1;
        if ({1'b0, idx} == cnt - (AW+1)'(1)) begin
          state_n = RUN;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = INSTR;
        end
      end
      RUN: begin
        if (accept) begin
          base_n  = base_addr;
          cnt_n   = (count > DEPTH_C) ? DEPTH_C : count;
          idx_n   = '0;
          state_n = ADDR;
        end else begin
          start_n = 1'b1;
          done_n  = !start;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = valid_n || (state_n inside {ADDR, INSTR, OPER});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      base       <= 8'd0;
      cnt        <= '0;
      idx        <= '0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      base       <= base_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      start      <= start_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: scoreboard of expected stream bytes plus a
// table of transfers and hand-written corner-case sequences.
`default_nettype none

module tb_prog_loader;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_instr = 8'd0;
  logic [7:0]    wr_oper = 8'd0;
  logic [7:0]    base_addr = 8'd0;
  logic [AW:0]   count = '0;
  logic          go = 1'b0;
  logic [7:0]    data_out;
  logic          data_valid;
  logic          start;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_instr [DEPTH];
  logic [7:0] m_oper  [DEPTH];
  logic [7:0] exp_q [$];
  logic [7:0] mon_e;

  typedef struct {
    logic [7:0]  base;
    logic [AW:0] cnt;
    int          nbytes;
  } vec_t;

  vec_t vecs [5];

  prog_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_instr  (wr_instr),
    .wr_oper   (wr_oper),
    .base_addr (base_addr),
    .count     (count),
    .go        (go),
    .data_out  (data_out),
    .data_valid(data_valid),
    .start     (start),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every valid byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%0h required=none", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_byte", {24'd0, data_out}, {24'd0, mon_e});
      end
    end
    check("start_and_valid_exclusive", {31'd0, start & data_valid}, 32'd0);
  end

  task automatic write_pair(input int a, input logic [7:0] i, input logic [7:0] o);
    wr_en    = 1'b1;
    wr_addr  = AW'(a);
    wr_instr = i;
    wr_oper  = o;
    m_instr[a] = i;
    m_oper[a]  = o;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_model(input logic [7:0] b, input logic [AW:0] c);
    int n;
    n = (c > DEPTH) ? DEPTH : int'(c);
    exp_q.push_back(b);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_instr[i]);
      exp_q.push_back(m_oper[i]);
    end
  endtask

  // Launches a transfer and checks framing; byte values go through the scoreboard.
  // At byte disturb_at, a go and a write to pair 0 are attempted while busy.
  task automatic run_transfer(input logic [7:0] b, input logic [AW:0] c,
                              input int nbytes, input int disturb_at);
    base_addr = b;
    count     = c;
    go        = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", {31'd0, busy}, 32'd1);
    check("no_valid_after_go", {31'd0, data_valid}, 32'd0);
    check("start_low_after_go", {31'd0, start}, 32'd0);
    for (int k = 0; k < nbytes; k++) begin
      if (k == disturb_at) begin
        go        = 1'b1;
        base_addr = 8'h99;
        count     = 5'd1;
        wr_en     = 1'b1;
        wr_addr   = '0;
        wr_instr  = 8'h0C;
        wr_oper   = 8'hFF;
      end
      @(negedge clk);
      go    = 1'b0;
      wr_en = 1'b0;
      check("valid_contiguous", {31'd0, data_valid}, 32'd1);
      if (k < nbytes - 1) check("busy_in_stream", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("start_after_stream", {31'd0, start}, 32'd1);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_clear_in_run", {31'd0, busy}, 32'd0);
    check("valid_clear_in_run", {31'd0, data_valid}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("start_held", {31'd0, start}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h40, 5'd0,  1};
    vecs[1] = '{8'h33, 5'd19, 33};
    vecs[2] = '{8'h5A, 5'd16, 33};
    vecs[3] = '{8'h77, 5'd1,  3};
    vecs[4] = '{8'hC8, 5'd5,  11};

    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic three-pair stream with literal expectations.
    write_pair(0, 8'h01, 8'h05);
    write_pair(1, 8'h02, 8'h07);
    write_pair(2, 8'h08, 8'h00);
    exp_q = '{8'h10, 8'h01, 8'h05, 8'h02, 8'h07, 8'h08, 8'h00};
    run_transfer(8'h10, 5'd3, 7, -1);

    // go and a write while busy must not disturb the stream.
    exp_q = '{8'h10, 8'h01, 8'h05, 8'h02, 8'h07, 8'h08, 8'h00};
    run_transfer(8'h10, 5'd3, 7, 0);

    // Refill the whole buffer from RUN, then run the table.
    for (int i = 0; i < DEPTH; i++) write_pair(i, 8'hA0 + 8'(i), 8'h5F - 8'(3 * i));
    for (int v = 0; v < 5; v++) begin
      push_model(vecs[v].base, vecs[v].cnt);
      run_transfer(vecs[v].base, vecs[v].cnt, vecs[v].nbytes, -1);
    end

    // Reset while instr1 is on the bus, then replay.
    exp_q = '{8'h21, m_instr[0], m_oper[0], m_instr[1]};
    base_addr = 8'h21;
    count     = 5'd3;
    go        = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    check("instr1_before_reset", {24'd0, data_out}, {24'd0, m_instr[1]});
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", {31'd0, data_valid}, 32'd0);
    check("abort_start", {31'd0, start}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data_out", {24'd0, data_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_queue_drained", exp_q.size(), 32'd0);
    push_model(8'h21, 5'd3);
    run_transfer(8'h21, 5'd3, 7, -1);

    // Relaunch from RUN: start must drop right after go.
    push_model(8'h20, 5'd1);
    run_transfer(8'h20, 5'd1, 3, -1);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
